// File: rtl/dram_id_remapper_pkg.sv
// Shared types and sizing helpers for the DRAM-side AXI ID remapper.
// Default AXI bundles use an 8-bit SoC ID and a 4-bit DRAM ID.
package dram_id_remapper_pkg;

  function automatic int cnt_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DefSlvIdW = 8;
  localparam int DefMstIdW = 4;

  typedef struct packed {
    logic [DefSlvIdW-1:0] id;
    logic [31:0]          addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } slv_ax_t;

  typedef struct packed {
    logic [DefMstIdW-1:0] id;
    logic [31:0]          addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } mst_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [DefSlvIdW-1:0] id;
    logic [1:0]           resp;
  } slv_b_t;

  typedef struct packed {
    logic [DefMstIdW-1:0] id;
    logic [1:0]           resp;
  } mst_b_t;

  typedef struct packed {
    logic [DefSlvIdW-1:0] id;
    logic [31:0]          data;
    logic [1:0]           resp;
    logic                 last;
  } slv_r_t;

  typedef struct packed {
    logic [DefMstIdW-1:0] id;
    logic [31:0]          data;
    logic [1:0]           resp;
    logic                 last;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    slv_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    slv_b_t b;
    logic   b_valid;
    slv_r_t r;
    logic   r_valid;
  } axi_slv_resp_t;

  typedef struct packed {
    mst_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    mst_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    mst_b_t b;
    logic   b_valid;
    mst_r_t r;
    logic   r_valid;
  } axi_mst_resp_t;

endpackage

// File: rtl/dram_id_remap_table.sv
// One-direction ID remap table: slave ID -> entry index used as master ID,
// with per-entry outstanding counters for ordering and back-pressure.
module dram_id_remap_table
  import dram_id_remapper_pkg::*;
#(
  parameter int unsigned SlvIdWidth   = 8,
  parameter int unsigned MstIdWidth   = 4,
  parameter int unsigned MaxUniqIds   = 16,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [SlvIdWidth-1:0] req_id_i,
  input  logic                  req_hs_i,
  input  logic                  rsp_hs_i,
  input  logic [MstIdWidth-1:0] rsp_id_i,
  output logic                  req_stall_o,
  output logic [MstIdWidth-1:0] req_mst_id_o,
  output logic [SlvIdWidth-1:0] rsp_slv_id_o,
  output logic                  full_o
);

  localparam int unsigned CntW = cnt_width(MaxTxnsPerId);
  localparam int unsigned IdxW = idx_width(MaxUniqIds);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

  logic [MaxUniqIds-1:0] valid_q, valid_d;
  logic [MaxUniqIds-1:0] inc, dec;
  logic [SlvIdWidth-1:0] slv_id_q [MaxUniqIds];
  logic [SlvIdWidth-1:0] slv_id_d [MaxUniqIds];
  logic [CntW-1:0]       cnt_q    [MaxUniqIds];
  logic [CntW-1:0]       cnt_d    [MaxUniqIds];
  logic                  full_q;

  logic            hit, free, rsp_ok;
  logic [IdxW-1:0] hit_idx, free_idx, sel_idx;

  // Lookup works on registered state only, so a freed entry is
  // allocatable no earlier than the cycle after its release.
  always_comb begin
    hit          = 1'b0;
    free         = 1'b0;
    hit_idx      = '0;
    free_idx     = '0;
    rsp_ok       = 1'b0;
    rsp_slv_id_o = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (!hit && valid_q[i] && slv_id_q[i] == req_id_i) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!free && !valid_q[i]) begin
        free     = 1'b1;
        free_idx = IdxW'(i);
      end
      if (valid_q[i] && rsp_id_i == MstIdWidth'(i)) begin
        rsp_ok       = 1'b1;
        rsp_slv_id_o = slv_id_q[i];
      end
    end
    sel_idx      = hit ? hit_idx : free_idx;
    req_mst_id_o = MstIdWidth'(sel_idx);
    req_stall_o  = req_valid_i &
                   (hit ? (cnt_q[hit_idx] == CntMax) : !free);
  end

  always_comb begin
    inc     = '0;
    dec     = '0;
    valid_d = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      inc[i] = req_hs_i && sel_idx == IdxW'(i);
      dec[i] = rsp_hs_i && valid_q[i] &&
               rsp_id_i == MstIdWidth'(i);
      cnt_d[i]    = cnt_q[i] + CntW'(inc[i]) - CntW'(dec[i]);
      valid_d[i]  = cnt_d[i] != '0;
      slv_id_d[i] = (inc[i] && !valid_q[i]) ? req_id_i
                                            : slv_id_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        cnt_q[i]    <= '0;
        slv_id_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      full_q  <= &valid_d;
      for (int i = 0; i < MaxUniqIds; i++) begin
        cnt_q[i]    <= cnt_d[i];
        slv_id_q[i] <= slv_id_d[i];
      end
    end
  end

  assign full_o = full_q;

`ifndef SYNTHESIS
  rsp_entry_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_hs_i |-> rsp_ok
  );
`endif

endmodule

// File: rtl/dram_id_remapper.sv
// AXI ID remapper toward the DRAM controller: wide SoC IDs are squeezed
// into narrow controller IDs via independent write and read tables.
module dram_id_remapper
  import dram_id_remapper_pkg::*;
#(
  parameter int unsigned SlvIdWidth   = 8,
  parameter int unsigned MstIdWidth   = 4,
  parameter int unsigned MaxUniqIds   = 16,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter type slv_req_t  = axi_slv_req_t,
  parameter type slv_resp_t = axi_slv_resp_t,
  parameter type mst_req_t  = axi_mst_req_t,
  parameter type mst_resp_t = axi_mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i,
  output logic      wr_full_o,
  output logic      rd_full_o
);

  if (MstIdWidth > SlvIdWidth || MaxUniqIds < 1 ||
      MaxUniqIds > 2**MstIdWidth || MaxTxnsPerId < 1) begin : g_bad_cfg
    $error("dram_id_remapper: illegal parameter set");
  end

  logic                  wr_stall, rd_stall;
  logic [MstIdWidth-1:0] wr_mst_id, rd_mst_id;
  logic [SlvIdWidth-1:0] wr_slv_id, rd_slv_id;
  logic                  aw_hs, ar_hs, b_hs, r_last_hs;

  assign aw_hs = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~wr_stall;
  assign ar_hs = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~rd_stall;
  assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready &
                     mst_resp_i.r.last;

  dram_id_remap_table #(
    .SlvIdWidth  (SlvIdWidth),
    .MstIdWidth  (MstIdWidth),
    .MaxUniqIds  (MaxUniqIds),
    .MaxTxnsPerId(MaxTxnsPerId)
  ) u_wr_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (slv_req_i.aw_valid),
    .req_id_i    (slv_req_i.aw.id),
    .req_hs_i    (aw_hs),
    .rsp_hs_i    (b_hs),
    .rsp_id_i    (mst_resp_i.b.id),
    .req_stall_o (wr_stall),
    .req_mst_id_o(wr_mst_id),
    .rsp_slv_id_o(wr_slv_id),
    .full_o      (wr_full_o)
  );

  dram_id_remap_table #(
    .SlvIdWidth  (SlvIdWidth),
    .MstIdWidth  (MstIdWidth),
    .MaxUniqIds  (MaxUniqIds),
    .MaxTxnsPerId(MaxTxnsPerId)
  ) u_rd_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (slv_req_i.ar_valid),
    .req_id_i    (slv_req_i.ar.id),
    .req_hs_i    (ar_hs),
    .rsp_hs_i    (r_last_hs),
    .rsp_id_i    (mst_resp_i.r.id),
    .req_stall_o (rd_stall),
    .req_mst_id_o(rd_mst_id),
    .rsp_slv_id_o(rd_slv_id),
    .full_o      (rd_full_o)
  );

  // Handshake outputs are masked while in reset so the port looks idle.
  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;

    mst_req_o.aw.id    = wr_mst_id;
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~wr_stall & rst_ni;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_stall & rst_ni;

    mst_req_o.w         = slv_req_i.w;
    mst_req_o.w_valid   = slv_req_i.w_valid & rst_ni;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & rst_ni;

    slv_resp_o.b.id     = wr_slv_id;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid & rst_ni;
    mst_req_o.b_ready   = slv_req_i.b_ready & rst_ni;

    mst_req_o.ar.id    = rd_mst_id;
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~rd_stall & rst_ni;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_stall & rst_ni;

    slv_resp_o.r.id     = rd_slv_id;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r_valid  = mst_resp_i.r_valid & rst_ni;
    mst_req_o.r_ready   = slv_req_i.r_ready & rst_ni;
  end

endmodule

// File: tb/tb_dram_id_remapper.sv
// Directed bench for dram_id_remapper with a 2-entry, 2-deep table.
// Stimulus is driven 1 ns after posedge and checked 1 ns later.
module tb_dram_id_remapper;
  import dram_id_remapper_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni;
  axi_slv_req_t  slv_req;
  axi_slv_resp_t slv_resp;
  axi_mst_req_t  mst_req;
  axi_mst_resp_t mst_resp;
  logic          wr_full, rd_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dram_id_remapper #(
    .SlvIdWidth  (8),
    .MstIdWidth  (4),
    .MaxUniqIds  (2),
    .MaxTxnsPerId(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .wr_full_o (wr_full),
    .rd_full_o (rd_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [7:0] id);
    slv_req.aw.id    = id;
    slv_req.aw_valid = 1'b1;
    #1;
  endtask

  task automatic ar(input logic [7:0] id);
    slv_req.ar.id    = id;
    slv_req.ar_valid = 1'b1;
    #1;
  endtask

  task automatic b(input logic [3:0] id);
    mst_resp.b.id    = id;
    mst_resp.b_valid = 1'b1;
    #1;
  endtask

  task automatic r(input logic [3:0] id, input logic last,
                   input logic [31:0] data);
    mst_resp.r.id    = id;
    mst_resp.r.last  = last;
    mst_resp.r.data  = data;
    mst_resp.r_valid = 1'b1;
    #1;
  endtask

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    rst_ni   = 1'b0;
    slv_req.aw_valid   = 1'b1;
    slv_req.ar_valid   = 1'b1;
    slv_req.w_valid    = 1'b1;
    slv_req.b_ready    = 1'b1;
    slv_req.r_ready    = 1'b1;
    mst_resp.aw_ready  = 1'b1;
    mst_resp.ar_ready  = 1'b1;
    mst_resp.w_ready   = 1'b1;
    mst_resp.b_valid   = 1'b1;
    mst_resp.r_valid   = 1'b1;
    #2;
    chk("rst_aw_valid", 32'(mst_req.aw_valid), 32'h0);
    chk("rst_aw_ready", 32'(slv_resp.aw_ready), 32'h0);
    chk("rst_ar_valid", 32'(mst_req.ar_valid), 32'h0);
    chk("rst_b_valid", 32'(slv_resp.b_valid), 32'h0);
    chk("rst_r_valid", 32'(slv_resp.r_valid), 32'h0);
    chk("rst_w_valid", 32'(mst_req.w_valid), 32'h0);
    chk("rst_wr_full", 32'(wr_full), 32'h0);
    chk("rst_rd_full", 32'(rd_full), 32'h0);
    tick();
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    rst_ni = 1'b1;
    tick();

    // single write round trip
    slv_req.aw.addr = 32'h1000;
    slv_req.aw.len  = 8'd0;
    aw(8'h5A);
    chk("t1_aw_id", 32'(mst_req.aw.id), 32'h0);
    chk("t1_aw_valid", 32'(mst_req.aw_valid), 32'h1);
    chk("t1_aw_addr", mst_req.aw.addr, 32'h1000);
    chk("t1_aw_ready", 32'(slv_resp.aw_ready), 32'h1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w.data   = 32'hDEADBEEF;
    slv_req.w_valid  = 1'b1;
    b(4'd0);
    chk("t1_b_id", 32'(slv_resp.b.id), 32'h5A);
    chk("t1_b_valid", 32'(slv_resp.b_valid), 32'h1);
    chk("t1_w_data", mst_req.w.data, 32'hDEADBEEF);
    chk("t1_w_valid", 32'(mst_req.w_valid), 32'h1);
    tick();
    mst_resp.b_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    #1;
    chk("t1_wr_full", 32'(wr_full), 32'h0);

    // same ID reuses its master ID
    aw(8'h10);
    chk("t2_aw0_id", 32'(mst_req.aw.id), 32'h0);
    tick();
    aw(8'h20);
    chk("t2_aw1_id", 32'(mst_req.aw.id), 32'h1);
    tick();
    aw(8'h10);
    chk("t2_aw2_id", 32'(mst_req.aw.id), 32'h0);
    chk("t2_aw2_ready", 32'(slv_resp.aw_ready), 32'h1);
    tick();
    slv_req.aw_valid = 1'b0;
    #1;
    chk("t2_full", 32'(wr_full), 32'h1);
    b(4'd0);
    chk("t2_b0_id", 32'(slv_resp.b.id), 32'h10);
    tick();
    b(4'd0);
    chk("t2_b1_id", 32'(slv_resp.b.id), 32'h10);
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("t2_full_clr", 32'(wr_full), 32'h0);
    b(4'd1);
    chk("t2_b2_id", 32'(slv_resp.b.id), 32'h20);
    tick();
    mst_resp.b_valid = 1'b0;

    // table exhaustion and release
    aw(8'h01);
    chk("t3_aw0_id", 32'(mst_req.aw.id), 32'h0);
    tick();
    aw(8'h02);
    chk("t3_aw1_id", 32'(mst_req.aw.id), 32'h1);
    chk("t3_full_lag", 32'(wr_full), 32'h0);
    tick();
    aw(8'h03);
    chk("t3_full", 32'(wr_full), 32'h1);
    chk("t3_stall_rdy", 32'(slv_resp.aw_ready), 32'h0);
    chk("t3_stall_vld", 32'(mst_req.aw_valid), 32'h0);
    b(4'd1);
    chk("t3_b_id", 32'(slv_resp.b.id), 32'h02);
    chk("t3_still_stall", 32'(slv_resp.aw_ready), 32'h0);
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("t3_accept_rdy", 32'(slv_resp.aw_ready), 32'h1);
    chk("t3_accept_id", 32'(mst_req.aw.id), 32'h1);
    tick();
    slv_req.aw_valid = 1'b0;
    b(4'd0);
    chk("t3_drain0", 32'(slv_resp.b.id), 32'h01);
    tick();
    b(4'd1);
    chk("t3_drain1", 32'(slv_resp.b.id), 32'h03);
    tick();
    mst_resp.b_valid = 1'b0;

    // per-ID depth limit, R burst release on last only
    ar(8'h07);
    chk("t4_ar0_id", 32'(mst_req.ar.id), 32'h0);
    tick();
    ar(8'h07);
    chk("t4_ar1_id", 32'(mst_req.ar.id), 32'h0);
    tick();
    ar(8'h07);
    chk("t4_ar_stall", 32'(slv_resp.ar_ready), 32'h0);
    chk("t4_ar_vld0", 32'(mst_req.ar_valid), 32'h0);
    chk("t4_rd_full", 32'(rd_full), 32'h0);
    aw(8'h09);
    chk("t4_aw_rdy", 32'(slv_resp.aw_ready), 32'h1);
    chk("t4_aw_id", 32'(mst_req.aw.id), 32'h0);
    tick();
    slv_req.aw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) b(4'd0);
      else mst_resp.b_valid = 1'b0;
      r(4'd0, k == 3, 32'hA000_0000 + 32'(k));
      chk("t4_r_id", 32'(slv_resp.r.id), 32'h07);
      chk("t4_r_data", slv_resp.r.data, 32'hA000_0000 + 32'(k));
      chk("t4_hold", 32'(slv_resp.ar_ready), 32'h0);
      if (k == 0) chk("t4_b_id", 32'(slv_resp.b.id), 32'h09);
      tick();
    end

    // AR hit and R last on the same entry in one cycle
    r(4'd0, 1'b1, 32'h5555);
    chk("t5_ar_rdy", 32'(slv_resp.ar_ready), 32'h1);
    chk("t5_ar_vld", 32'(mst_req.ar_valid), 32'h1);
    chk("t5_ar_id", 32'(mst_req.ar.id), 32'h0);
    chk("t5_r_id", 32'(slv_resp.r.id), 32'h07);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    ar(8'h08);
    chk("t5_keep_valid", 32'(mst_req.ar.id), 32'h1);
    tick();
    slv_req.ar_valid = 1'b0;
    #1;
    chk("t5_rd_full", 32'(rd_full), 32'h1);
    r(4'd0, 1'b1, 32'h0);
    chk("t5_drain0", 32'(slv_resp.r.id), 32'h07);
    tick();
    r(4'd1, 1'b1, 32'h0);
    chk("t5_drain1", 32'(slv_resp.r.id), 32'h08);
    tick();
    mst_resp.r_valid = 1'b0;
    #1;
    chk("t5_rd_free", 32'(rd_full), 32'h0);

    // reset with four writes in flight
    aw(8'h0A);
    chk("t6_aw0", 32'(mst_req.aw.id), 32'h0);
    tick();
    aw(8'h0A);
    chk("t6_aw1", 32'(mst_req.aw.id), 32'h0);
    tick();
    aw(8'h0B);
    chk("t6_aw2", 32'(mst_req.aw.id), 32'h1);
    tick();
    aw(8'h0B);
    chk("t6_aw3", 32'(mst_req.aw.id), 32'h1);
    tick();
    aw(8'h33);
    chk("t6_full", 32'(wr_full), 32'h1);
    b(4'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_aw_vld", 32'(mst_req.aw_valid), 32'h0);
    chk("t6_rst_aw_rdy", 32'(slv_resp.aw_ready), 32'h0);
    chk("t6_rst_b_vld", 32'(slv_resp.b_valid), 32'h0);
    chk("t6_rst_full", 32'(wr_full), 32'h0);
    tick();
    mst_resp.b_valid = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("t6_new_id", 32'(mst_req.aw.id), 32'h0);
    chk("t6_new_vld", 32'(mst_req.aw_valid), 32'h1);
    chk("t6_new_rdy", 32'(slv_resp.aw_ready), 32'h1);
    tick();
    slv_req.aw_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
